// File: rtl/mem_port_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mem_arb_pkg
// Shared types and constants for the instruction/data memory port arbiter.
//   state_t      : transaction sequencer states (IDLE, BUSY, RESP)
//   OWN_IF/OWN_D : encoding of the owner output (0 = fetch, 1 = data)
//   DEF_*_W      : default address/data widths
//   cnt_width()  : width of the optional timeout counter (8 bits minimum)
// ---------------------------------------------------------------------------
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_D  = 1'b1;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  // Counter must hold max_val and is never narrower than 8 bits.
  function automatic int cnt_width(input int max_val);
    int w;
    w = $clog2(max_val + 1);
    return (w < 8) ? 8 : w;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter_if
// Bundles the fetch port, the load/store port, the memory port and the
// status outputs of the arbiter.
//   master : arbiter side (drives acks, rdata, memory request, status)
//   slave  : environment side (CPU core and memory model)
// Fetch : if_req, if_addr -> if_rdata, if_ack, if_err
// Data  : d_req, d_we, d_addr, d_wdata -> d_rdata, d_ack, d_err
// Memory: mem_req, mem_we, mem_addr, mem_wdata <- mem_rdata, mem_ready
// Status: busy, owner
// ---------------------------------------------------------------------------
interface mem_port_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ack;
  logic              if_err;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_ack;
  logic              d_err;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  logic              busy;
  logic              owner;

  modport master (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
    output if_rdata, if_ack, if_err, d_rdata, d_ack, d_err,
    output mem_req, mem_we, mem_addr, mem_wdata, busy, owner
  );

  modport slave (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
    input  if_rdata, if_ack, if_err, d_rdata, d_ack, d_err,
    input  mem_req, mem_we, mem_addr, mem_wdata, busy, owner
  );

endinterface

// File: rtl/mem_port_arbiter_arb_grant2.sv
// ---------------------------------------------------------------------------
// arb_grant2
// Combinational two-way grant between the fetch and data ports.
//   i_if_req, i_d_req : request levels
//   i_rr_last         : owner of the most recent grant
//   o_grant           : some port is requesting
//   o_owner           : winning port (OWN_IF / OWN_D)
// DATA_PRIO=1: data always wins a tie. DATA_PRIO=0: the port not served
// last wins a tie.
// ---------------------------------------------------------------------------
module arb_grant2
  import mem_arb_pkg::*;
#(
  parameter int DATA_PRIO = 1
) (
  input  logic i_if_req,
  input  logic i_d_req,
  input  logic i_rr_last,
  output logic o_grant,
  output logic o_owner
);

  always_comb begin
    o_grant = i_if_req | i_d_req;
    o_owner = OWN_IF;
    if (i_if_req && i_d_req) begin
      // Round-robin: invert the last owner so the other port goes next.
      o_owner = (DATA_PRIO != 0) ? OWN_D : ~i_rr_last;
    end else if (i_d_req) begin
      o_owner = OWN_D;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
// Shares a single-port memory between the instruction-fetch path and the
// load/store path, one transaction at a time (IDLE -> BUSY -> RESP).
//   clk  : system clock (rising edge)
//   rst  : synchronous active-high reset
//   bus  : mem_port_arbiter_if.master (fetch, data, memory, status signals)
// Optional macro ARB_TIMEOUT_EN: abort a transaction after TIMEOUT_CYC
// BUSY cycles without mem_ready, returning ack with err=1.
// ---------------------------------------------------------------------------
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int DATA_PRIO   = 1,
  parameter int TIMEOUT_CYC = 255
) (
  input logic              clk,
  input logic              rst,
  mem_port_arbiter_if.master bus
);

  state_t            r_state;
  state_t            w_state_next;
  logic              w_grant;
  logic              w_owner;
  logic              w_start;
  logic              w_complete;
  logic              w_abort;
  logic              w_timeout;

  logic              r_rr_last;
  logic              r_owner;
  logic              r_mem_req;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [DATA_W-1:0] r_if_rdata;
  logic [DATA_W-1:0] r_d_rdata;
  logic              r_if_ack;
  logic              r_d_ack;

  arb_grant2 #(.DATA_PRIO(DATA_PRIO)) u_grant (
    .i_if_req  (bus.if_req),
    .i_d_req   (bus.d_req),
    .i_rr_last (r_rr_last),
    .o_grant   (w_grant),
    .o_owner   (w_owner)
  );

  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    w_complete   = 1'b0;
    w_abort      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_grant) begin
          w_start      = 1'b1;
          w_state_next = BUSY;
        end
      end
      BUSY: begin
        // A completing memory wins over a timeout in the same cycle.
        if (bus.mem_ready) begin
          w_complete   = 1'b1;
          w_state_next = RESP;
        end else if (w_timeout) begin
          w_abort      = 1'b1;
          w_state_next = RESP;
        end
      end
      RESP:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_last   <= OWN_IF;
      r_owner     <= OWN_IF;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_if_rdata  <= '0;
      r_d_rdata   <= '0;
      r_if_ack    <= 1'b0;
      r_d_ack     <= 1'b0;
    end else begin
      r_if_ack <= 1'b0;
      r_d_ack  <= 1'b0;
      if (w_start) begin
        // Latch the winner's request so later input changes are ignored.
        r_owner     <= w_owner;
        r_rr_last   <= w_owner;
        r_mem_req   <= 1'b1;
        r_mem_we    <= (w_owner == OWN_D) && bus.d_we;
        r_mem_addr  <= (w_owner == OWN_D) ? bus.d_addr : bus.if_addr;
        r_mem_wdata <= bus.d_wdata;
      end
      if (w_complete) begin
        r_mem_req <= 1'b0;
        if (r_owner == OWN_D) begin
          r_d_ack <= 1'b1;
          if (!r_mem_we) begin
            r_d_rdata <= bus.mem_rdata;
          end
        end else begin
          r_if_ack   <= 1'b1;
          r_if_rdata <= bus.mem_rdata;
        end
      end
      if (w_abort) begin
        r_mem_req <= 1'b0;
        r_d_ack   <= (r_owner == OWN_D);
        r_if_ack  <= (r_owner == OWN_IF);
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = cnt_width(TIMEOUT_CYC);

  logic [CNT_W-1:0] r_to_cnt;
  logic             r_if_err;
  logic             r_d_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_to_cnt <= '0;
      r_if_err <= 1'b0;
      r_d_err  <= 1'b0;
    end else begin
      r_if_err <= 1'b0;
      r_d_err  <= 1'b0;
      if (w_start) begin
        r_to_cnt <= '0;
      end else if ((r_state == BUSY) && !bus.mem_ready) begin
        r_to_cnt <= r_to_cnt + 1'b1;
      end
      if (w_abort) begin
        r_d_err  <= (r_owner == OWN_D);
        r_if_err <= (r_owner == OWN_IF);
      end
    end
  end

  // Fires during the TIMEOUT_CYC-th waiting cycle, so that edge aborts.
  assign w_timeout  = (r_state == BUSY) && (r_to_cnt == CNT_W'(TIMEOUT_CYC - 1));
  assign bus.if_err = r_if_err;
  assign bus.d_err  = r_d_err;
`else
  // Always 0; TIMEOUT_CYC is referenced only to keep one parameter list.
  assign w_timeout  = (TIMEOUT_CYC < 0);
  assign bus.if_err = 1'b0;
  assign bus.d_err  = 1'b0;
`endif

  assign bus.mem_req   = r_mem_req;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.if_rdata  = r_if_rdata;
  assign bus.if_ack    = r_if_ack;
  assign bus.d_rdata   = r_d_rdata;
  assign bus.d_ack     = r_d_ack;
  assign bus.busy      = (r_state != IDLE);
  assign bus.owner     = r_owner;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
// Two arbiter instances (g_inst[0]: data priority, g_inst[1]: round-robin),
// each with its own requesters, memory responder and transaction-level
// reference model. Directed scenarios first, then randomized traffic.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mem_port_arbiter;

  localparam int TB_TO = 4;

  logic clk;
  int   tests;
  int   fails;
  int   done_cnt;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input int inst, input string name,
                       input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL g%0d %s: got %0h, required %0h (t=%0t)", inst, name, got, exp, $time);
    end
  endtask

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_inst
      localparam int PRIO = (gi == 0) ? 1 : 0;

      mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

      logic        rst_i;
      bit          chk_en;
      bit          rnd_mode;
      int          mem_delay;
      logic [31:0] mem_data;
      int          mcnt;
      int          mdly;

      mem_port_arbiter #(
        .ADDR_W(32), .DATA_W(32), .DATA_PRIO(PRIO), .TIMEOUT_CYC(TB_TO)
      ) dut (
        .clk (clk),
        .rst (rst_i),
        .bus (bus.master)
      );

      // Memory responder: answers mem_req after a programmable wait;
      // in random mode also raises spurious mem_ready while idle.
      always @(posedge clk) begin
        #1;
        if (rst_i || !bus.mem_req) begin
          bus.mem_ready = rnd_mode ? ($urandom_range(0, 3) == 0) : 1'b0;
          bus.mem_rdata = $urandom;
          mcnt = 0;
          mdly = rnd_mode ? int'($urandom_range(0, 3)) : mem_delay;
        end else if (mcnt >= mdly) begin
          bus.mem_ready = 1'b1;
          bus.mem_rdata = rnd_mode ? $urandom : mem_data;
        end else begin
          bus.mem_ready = 1'b0;
          mcnt++;
        end
      end

      // Reference model: one outstanding transaction; grant, memory phase,
      // one response cycle, back to idle.
      logic        m_busy, m_memreq, m_owner, m_we, m_last, m_resp;
      logic        m_if_ack, m_d_ack, m_if_err, m_d_err;
      logic [31:0] m_addr, m_wdata, m_if_rdata, m_d_rdata;
      int          m_wait;

      always @(posedge clk) begin
        if (rst_i) begin
          m_busy = 0; m_memreq = 0; m_owner = 0; m_we = 0; m_last = 0; m_resp = 0;
          m_if_ack = 0; m_d_ack = 0; m_if_err = 0; m_d_err = 0;
          m_addr = 0; m_wdata = 0; m_if_rdata = 0; m_d_rdata = 0; m_wait = 0;
        end else begin
          m_if_ack = 0; m_d_ack = 0; m_if_err = 0; m_d_err = 0;
          if (m_resp) begin
            m_resp = 0;
            m_busy = 0;
          end else if (!m_busy) begin
            if (bus.if_req || bus.d_req) begin
              if (bus.if_req && bus.d_req) m_owner = (PRIO != 0) ? 1'b1 : !m_last;
              else m_owner = bus.d_req;
              m_last   = m_owner;
              m_busy   = 1;
              m_memreq = 1;
              m_wait   = 0;
              m_we     = m_owner && bus.d_we;
              m_addr   = m_owner ? bus.d_addr : bus.if_addr;
              m_wdata  = bus.d_wdata;
            end
          end else if (bus.mem_ready) begin
            m_memreq = 0;
            m_resp   = 1;
            if (m_owner) begin
              m_d_ack = 1;
              if (!m_we) m_d_rdata = bus.mem_rdata;
            end else begin
              m_if_ack   = 1;
              m_if_rdata = bus.mem_rdata;
            end
          end else begin
            m_wait++;
`ifdef ARB_TIMEOUT_EN
            if (m_wait == TB_TO) begin
              m_memreq = 0;
              m_resp   = 1;
              m_d_ack  = m_owner;  m_d_err  = m_owner;
              m_if_ack = !m_owner; m_if_err = !m_owner;
            end
`endif
          end
        end
      end

      // Compare DUT against the model on every falling edge.
      always @(negedge clk) begin
        if (chk_en) begin
          check(gi, "busy", bus.busy, m_busy);
          check(gi, "mem_req", bus.mem_req, m_memreq);
          check(gi, "if_ack", bus.if_ack, m_if_ack);
          check(gi, "d_ack", bus.d_ack, m_d_ack);
          check(gi, "if_err", bus.if_err, m_if_err);
          check(gi, "d_err", bus.d_err, m_d_err);
          check(gi, "if_rdata", bus.if_rdata, m_if_rdata);
          check(gi, "d_rdata", bus.d_rdata, m_d_rdata);
          check(gi, "ack_excl", bus.if_ack & bus.d_ack, 0);
          if (m_busy) check(gi, "owner", bus.owner, m_owner);
          if (m_memreq) begin
            check(gi, "mem_we", bus.mem_we, m_we);
            check(gi, "mem_addr", bus.mem_addr, m_addr);
            if (m_we) check(gi, "mem_wdata", bus.mem_wdata, m_wdata);
          end
          if (m_if_ack || m_d_ack)
            $display("[TB] g%0d txn %s addr=%h we=%0d if_rdata=%h d_rdata=%h err=%0d",
                     gi, m_owner ? "D " : "IF", m_addr, m_we, m_if_rdata, m_d_rdata,
                     m_if_err | m_d_err);
        end
      end

      initial begin : stim
        int n;
        logic exp_owner;
        rst_i = 1; rnd_mode = 0; mem_delay = 0; mem_data = '0; chk_en = 0;
        bus.if_req = 0; bus.if_addr = '0;
        bus.d_req = 0; bus.d_we = 0; bus.d_addr = '0; bus.d_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_en = 1;
        check(gi, "rst_busy", bus.busy, 0);
        check(gi, "rst_mem_req", bus.mem_req, 0);
        check(gi, "rst_if_ack", bus.if_ack, 0);
        check(gi, "rst_d_ack", bus.d_ack, 0);
        check(gi, "rst_if_rdata", bus.if_rdata, 0);
        check(gi, "rst_d_rdata", bus.d_rdata, 0);
        check(gi, "rst_owner", bus.owner, 0);
        rst_i = 0;

        // Fetch read, memory answers two cycles after mem_req.
        mem_delay = 2; mem_data = 32'hDEADBEEF;
        bus.if_req = 1; bus.if_addr = 32'h10;
        @(posedge clk); #1;
        check(gi, "f_mem_req", bus.mem_req, 1);
        check(gi, "f_mem_addr", bus.mem_addr, 32'h10);
        check(gi, "f_mem_we", bus.mem_we, 0);
        n = 1;
        while (!bus.if_ack && n < 20) begin @(posedge clk); #1; n++; end
        check(gi, "f_latency", n, 4);
        check(gi, "f_if_rdata", bus.if_rdata, 32'hDEADBEEF);
        check(gi, "f_d_ack", bus.d_ack, 0);
        bus.if_req = 0;
        repeat (2) @(posedge clk);
        #1;

        // Data write, memory ready immediately.
        mem_delay = 0;
        bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h40; bus.d_wdata = 32'h12345678;
        @(posedge clk); #1;
        check(gi, "w_mem_we", bus.mem_we, 1);
        check(gi, "w_mem_wdata", bus.mem_wdata, 32'h12345678);
        check(gi, "w_mem_addr", bus.mem_addr, 32'h40);
        n = 1;
        while (!bus.d_ack && n < 20) begin @(posedge clk); #1; n++; end
        check(gi, "w_latency", n, 2);
        check(gi, "w_d_rdata", bus.d_rdata, 0);
        bus.d_req = 0; bus.d_we = 0;
        @(posedge clk); #1;

        // Contention from a fresh reset, both requests held.
        rst_i = 1; @(posedge clk); #1; rst_i = 0;
        mem_delay = 1;
        bus.if_req = 1; bus.if_addr = 32'h100;
        bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h200;
        for (int k = 0; k < 4; k++) begin
          n = 0;
          do begin @(posedge clk); #1; n++; end while (!(bus.if_ack || bus.d_ack) && n < 20);
          check(gi, "c_ack_wait", n < 20, 1);
          exp_owner = (PRIO != 0) ? 1'b1 : ((k % 2) == 0);
          check(gi, "c_owner_seq", bus.d_ack, exp_owner);
        end
        bus.d_req = 0;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!(bus.if_ack || bus.d_ack) && n < 20);
        check(gi, "c_fetch_after", bus.if_ack, 1);
        bus.if_req = 0;
        repeat (2) @(posedge clk);
        #1;

        // Reset while waiting on memory, then a normal fetch.
        mem_delay = 50;
        bus.if_req = 1; bus.if_addr = 32'h33;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!bus.mem_req && n < 10);
        check(gi, "r_mem_req_seen", bus.mem_req, 1);
        rst_i = 1;
        @(posedge clk); #1;
        check(gi, "r_mem_req", bus.mem_req, 0);
        check(gi, "r_busy", bus.busy, 0);
        check(gi, "r_if_ack", bus.if_ack, 0);
        rst_i = 0;
        mem_delay = 1; mem_data = 32'hCAFEF00D;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!bus.if_ack && n < 20);
        check(gi, "r_if_ack_after", bus.if_ack, 1);
        check(gi, "r_if_rdata", bus.if_rdata, 32'hCAFEF00D);
        bus.if_req = 0;
        repeat (2) @(posedge clk);
        #1;

        // Memory never answers.
        mem_delay = 100000;
        bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h44;
`ifdef ARB_TIMEOUT_EN
        @(posedge clk); #1;
        n = 0;
        while (bus.mem_req && n < 50) begin n++; @(posedge clk); #1; end
        check(gi, "t_busy_cycles", n, TB_TO);
        check(gi, "t_d_ack", bus.d_ack, 1);
        check(gi, "t_d_err", bus.d_err, 1);
        check(gi, "t_d_rdata", bus.d_rdata, 0);
        bus.d_req = 0;
        repeat (2) @(posedge clk);
        #1;
`else
        repeat (101) begin @(posedge clk); #1; end
        check(gi, "t_still_busy", bus.busy, 1);
        check(gi, "t_still_req", bus.mem_req, 1);
        check(gi, "t_no_ack", bus.d_ack, 0);
        bus.d_req = 0;
        rst_i = 1; @(posedge clk); #1; rst_i = 0;
`endif

        // Randomized traffic.
        rnd_mode = 1;
        repeat (1500) begin
          @(posedge clk); #1;
          rst_i = ($urandom_range(0, 299) == 0);
          if (bus.if_req && bus.if_ack) begin
            if ($urandom_range(0, 1) == 1) bus.if_addr = $urandom;
            else bus.if_req = 0;
          end else if (!bus.if_req) begin
            if ($urandom_range(0, 2) == 0) begin bus.if_req = 1; bus.if_addr = $urandom; end
          end else if ($urandom_range(0, 3) == 0) begin
            bus.if_addr = $urandom;
          end
          if (bus.d_req && bus.d_ack) begin
            if ($urandom_range(0, 1) == 1) begin
              bus.d_we = 1'($urandom_range(0, 1)); bus.d_addr = $urandom; bus.d_wdata = $urandom;
            end else begin
              bus.d_req = 0;
            end
          end else if (!bus.d_req) begin
            if ($urandom_range(0, 2) == 0) begin
              bus.d_req = 1; bus.d_we = 1'($urandom_range(0, 1));
              bus.d_addr = $urandom; bus.d_wdata = $urandom;
            end
          end else if ($urandom_range(0, 3) == 0) begin
            bus.d_we = 1'($urandom_range(0, 1)); bus.d_addr = $urandom; bus.d_wdata = $urandom;
          end
        end
        rst_i = 0; bus.if_req = 0; bus.d_req = 0; rnd_mode = 0;
        repeat (10) @(posedge clk);
        done_cnt++;
      end
    end
  endgenerate

  initial begin
    fork
      wait (done_cnt == 2);
      #500000;
    join_any
    if (done_cnt != 2) begin
      fails++;
      $display("FAIL watchdog: instances done %0d, required 2", done_cnt);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
